ipa_gcm_arbiter: RTL and testbench

//  Shares the two GCM SRAM banks between the IPA context-fetch engine (64-bit reads, both banks
//  at once) and NB_DMA 32-bit DMA ports (word-interleaved across the banks). Context fetch has

---
 rtl/ipa_gcm_pkg.sv | 22 ++
 rtl/ipa_gcm_arbiter_rr.sv | 46 ++++
 rtl/ipa_gcm_arbiter.sv | 159 +++++++++++++++
 tb/tb_ipa_gcm_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipa_gcm_pkg.sv
// rtl/ipa_gcm_pkg.sv - shared types and helpers for the GCM bank arbiter
package ipa_gcm_pkg;

  // Tag index width bounds NB_DMA to at most 16 ports.
  localparam int TAG_IDX_W = 4;

  typedef enum logic {ARB, YIELD} arb_state_e;

  typedef enum logic {OWN_CTX, OWN_DMA} owner_e;

  typedef struct packed {
    owner_e               owner;
    logic [TAG_IDX_W-1:0] idx;
    logic                 rd;
    logic                 valid;
  } bank_tag_t;

  function automatic logic bank_sel(input logic [2:0] addr_lo);
    return addr_lo[2];
  endfunction

endpackage

// File: rtl/ipa_gcm_arbiter_rr.sv
// rtl/ipa_gcm_arbiter_rr.sv - N-way round-robin arbiter, one instance per bank
module ipa_gcm_rr_arb #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          found
);

  logic [PW-1:0] ptr;

  always_comb begin
    int            k;
    logic [PW-1:0] cand;
    k     = 0;
    cand  = '0;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      cand = PW'(k);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

  // Pointer moves past the winner only when a grant was actually issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
    end
  end

endmodule

// File: rtl/ipa_gcm_arbiter.sv
// rtl/ipa_gcm_arbiter.sv - shares two GCM SRAM banks between context fetch and DMA ports
module ipa_gcm_arbiter
  import ipa_gcm_pkg::*;
#(
  parameter int NB_DMA         = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int ADDR_MEM_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int CTX_MAX_BURST  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NB_DMA-1:0]              dma_req_i,
  input  logic [NB_DMA*ADDR_WIDTH-1:0]   dma_add_i,
  input  logic [NB_DMA-1:0]              dma_wen_i,
  input  logic [NB_DMA*DATA_WIDTH-1:0]   dma_wdata_i,
  input  logic [NB_DMA*4-1:0]            dma_be_i,
  output logic [NB_DMA-1:0]              dma_gnt_o,
  output logic [NB_DMA-1:0]              dma_r_valid_o,
  output logic [NB_DMA*DATA_WIDTH-1:0]   dma_r_rdata_o,
  input  logic                           ctx_req_i,
  input  logic [ADDR_MEM_WIDTH-1:0]      ctx_add_i,
  output logic                           ctx_gnt_o,
  output logic                           ctx_r_valid_o,
  output logic [2*DATA_WIDTH-1:0]        ctx_r_rdata_o,
  output logic [1:0]                     bank_req_o,
  output logic [2*ADDR_MEM_WIDTH-1:0]    bank_add_o,
  output logic [1:0]                     bank_wen_o,
  output logic [2*DATA_WIDTH-1:0]        bank_wdata_o,
  output logic [7:0]                     bank_be_o,
  input  logic [2*DATA_WIDTH-1:0]        bank_rdata_i
);

  localparam int PW = (NB_DMA > 1) ? $clog2(NB_DMA) : 1;
  localparam int CW = $clog2(CTX_MAX_BURST + 1);

  arb_state_e                  state;
  logic [CW-1:0]               burst_cnt;
  logic                        any_dma;
  logic                        ctx_win;
  logic                        arb_en;
  logic [1:0][NB_DMA-1:0]      bank_dma_req;
  logic [1:0][NB_DMA-1:0]      bank_dma_gnt;
  logic [1:0][PW-1:0]          win_idx;
  logic [1:0]                  win_found;
  bank_tag_t                   tag [2];
  logic                        addr_unused;

  assign any_dma     = |dma_req_i;
  assign ctx_win     = !rst && ctx_req_i && (state == ARB);
  assign arb_en      = !rst && !ctx_win;
  assign ctx_gnt_o   = ctx_win;
  assign dma_gnt_o   = bank_dma_gnt[0] | bank_dma_gnt[1];
  assign addr_unused = ^dma_add_i;

  always_comb begin
    bank_dma_req = '0;
    for (int p = 0; p < NB_DMA; p++) begin
      bank_dma_req[bank_sel(dma_add_i[p*ADDR_WIDTH +: 3])][p] = dma_req_i[p];
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ipa_gcm_rr_arb #(.N(NB_DMA), .PW(PW)) u_rr (
      .clk   (clk),
      .rst   (rst),
      .req   (bank_dma_req[b]),
      .en    (arb_en),
      .gnt   (bank_dma_gnt[b]),
      .idx   (win_idx[b]),
      .found (win_found[b])
    );
  end

  always_comb begin
    int p;
    p            = 0;
    bank_req_o   = '0;
    bank_add_o   = '0;
    bank_wen_o   = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    for (int b = 0; b < 2; b++) begin
      if (ctx_win) begin
        bank_req_o[b]                          = 1'b1;
        bank_add_o[b*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH] = ctx_add_i;
        bank_wen_o[b]                          = 1'b1;
        bank_be_o[b*4 +: 4]                    = 4'hF;
      end else if (win_found[b]) begin
        p                                      = int'(win_idx[b]);
        bank_req_o[b]                          = 1'b1;
        bank_add_o[b*ADDR_MEM_WIDTH +: ADDR_MEM_WIDTH] = dma_add_i[p*ADDR_WIDTH+3 +: ADDR_MEM_WIDTH];
        bank_wen_o[b]                          = dma_wen_i[p];
        bank_wdata_o[b*DATA_WIDTH +: DATA_WIDTH] = dma_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        bank_be_o[b*4 +: 4]                    = dma_be_i[p*4 +: 4];
      end
    end
  end

  // The burst counter only runs while DMA is waiting; hitting the limit forces one DMA-only cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (ctx_req_i && any_dma) begin
            if (burst_cnt == CW'(CTX_MAX_BURST - 1)) begin
              state     <= YIELD;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + CW'(1);
            end
          end else begin
            burst_cnt <= '0;
          end
        end
        default: begin
          state     <= ARB;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        tag[b] <= '{owner: OWN_CTX, idx: '0, rd: 1'b0, valid: 1'b0};
      end else begin
        tag[b].valid <= bank_req_o[b];
        tag[b].owner <= ctx_win ? OWN_CTX : OWN_DMA;
        tag[b].idx   <= TAG_IDX_W'(win_idx[b]);
        tag[b].rd    <= bank_wen_o[b];
      end
    end
  end

  always_comb begin
    dma_r_valid_o = '0;
    dma_r_rdata_o = '0;
    ctx_r_valid_o = 1'b0;
    ctx_r_rdata_o = '0;
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < NB_DMA; p++) begin
        if (tag[b].valid && tag[b].owner == OWN_DMA && tag[b].idx == TAG_IDX_W'(p)) begin
          dma_r_valid_o[p] = 1'b1;
          if (tag[b].rd) dma_r_rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = bank_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    if (tag[0].valid && tag[0].owner == OWN_CTX) begin
      ctx_r_valid_o = 1'b1;
      ctx_r_rdata_o = {bank_rdata_i[0 +: DATA_WIDTH], bank_rdata_i[DATA_WIDTH +: DATA_WIDTH]};
    end
  end

endmodule

// File: tb/tb_ipa_gcm_arbiter.sv
// tb/tb_ipa_gcm_arbiter.sv - randomized and directed bench with a behavioural arbiter/memory model
module tb_ipa_gcm_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int AMW  = 12;
  localparam int DW   = 32;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [N-1:0]       dma_req, dma_wen, dma_gnt, dma_r_valid;
  logic [N*AW-1:0]    dma_add;
  logic [N*DW-1:0]    dma_wdata, dma_r_rdata;
  logic [N*4-1:0]     dma_be;
  logic               ctx_req, ctx_gnt, ctx_r_valid;
  logic [AMW-1:0]     ctx_add;
  logic [2*DW-1:0]    ctx_r_rdata;
  logic [1:0]         bank_req, bank_wen;
  logic [2*AMW-1:0]   bank_add;
  logic [2*DW-1:0]    bank_wdata, bank_rdata;
  logic [7:0]         bank_be;

  ipa_gcm_arbiter #(.NB_DMA(N), .ADDR_WIDTH(AW), .ADDR_MEM_WIDTH(AMW),
                    .DATA_WIDTH(DW), .CTX_MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .dma_req_i(dma_req), .dma_add_i(dma_add), .dma_wen_i(dma_wen),
    .dma_wdata_i(dma_wdata), .dma_be_i(dma_be), .dma_gnt_o(dma_gnt),
    .dma_r_valid_o(dma_r_valid), .dma_r_rdata_o(dma_r_rdata),
    .ctx_req_i(ctx_req), .ctx_add_i(ctx_add), .ctx_gnt_o(ctx_gnt),
    .ctx_r_valid_o(ctx_r_valid), .ctx_r_rdata_o(ctx_r_rdata),
    .bank_req_o(bank_req), .bank_add_o(bank_add), .bank_wen_o(bank_wen),
    .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata)
  );

  function automatic logic [31:0] init_val(int b, int w);
    return 32'h1000_0000 * 32'(b + 1) + 32'(w);
  endfunction

  // SRAM banks seen by the DUT; reset reloads the initial contents.
  logic [DW-1:0] env_mem [2][32];
  logic [DW-1:0] env_rd  [2];
  assign bank_rdata = {env_rd[1], env_rd[0]};

  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        env_rd[b] <= '0;
        for (int w = 0; w < 32; w++) env_mem[b][w] <= init_val(b, w);
      end else if (bank_req[b]) begin
        if (bank_wen[b]) env_rd[b] <= env_mem[b][bank_add[b*AMW +: 5]];
        else for (int k = 0; k < 4; k++)
          if (bank_be[b*4+k]) env_mem[b][bank_add[b*AMW +: 5]][8*k +: 8] <= bank_wdata[b*DW+8*k +: 8];
      end
    end
  end

  logic [N-1:0]  p_req, p_wen;
  logic [31:0]   p_addr  [N];
  logic [DW-1:0] p_wdata [N];
  logic [3:0]    p_be    [N];

  // Reference model: flat memory indexed by DMA byte address >> 2, plus arbitration rules.
  logic [DW-1:0] ref_mem [64];
  int            m_ptr [2];
  int            m_cnt;
  bit            m_yield;
  logic [N-1:0]  m_gnt;
  bit            m_ctx_gnt;
  logic [N-1:0]  pv_dma;
  logic [DW-1:0] pd_dma [N];
  bit            pv_ctx;
  logic [63:0]   pd_ctx;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      dma_req[p]            = p_req[p];
      dma_wen[p]            = p_wen[p];
      dma_add[p*AW +: AW]   = p_addr[p];
      dma_wdata[p*DW +: DW] = p_wdata[p];
      dma_be[p*4 +: 4]      = p_be[p];
    end
  endtask

  task automatic set_port(int p, bit rq, logic [31:0] a, bit rd, logic [31:0] d, logic [3:0] be);
    p_req[p] = rq; p_addr[p] = a; p_wen[p] = rd; p_wdata[p] = d; p_be[p] = be;
  endtask

  task automatic step();
    logic [N-1:0] eg;
    int  win [2];
    bit  anyd, cw;
    int  p, ri, ca;
    drive();
    @(negedge clk);
    if (!rst) begin
      for (int q = 0; q < N; q++) begin
        chk($sformatf("dma_r_valid[%0d]", q), 64'(dma_r_valid[q]), 64'(pv_dma[q]));
        if (pv_dma[q]) chk($sformatf("dma_r_rdata[%0d]", q), 64'(dma_r_rdata[q*DW +: DW]), 64'(pd_dma[q]));
      end
      chk("ctx_r_valid", 64'(ctx_r_valid), 64'(pv_ctx));
      if (pv_ctx) chk("ctx_r_rdata", ctx_r_rdata, pd_ctx);
    end
    anyd = |p_req;
    cw   = !rst && ctx_req && !m_yield;
    win[0] = -1; win[1] = -1; eg = '0;
    if (!rst && !cw)
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++) begin
          p = (m_ptr[b] + i) % N;
          if (win[b] < 0 && p_req[p] && int'(p_addr[p][2]) == b) win[b] = p;
        end
    for (int b = 0; b < 2; b++) if (win[b] >= 0) eg[win[b]] = 1'b1;
    chk("dma_gnt", 64'(dma_gnt), 64'(eg));
    chk("ctx_gnt", 64'(ctx_gnt), 64'(cw));
    chk("bank_req", 64'(bank_req), 64'({cw || win[1] >= 0, cw || win[0] >= 0}));
    for (int b = 0; b < 2; b++) begin
      if (cw) begin
        chk("bank_add_ctx", 64'(bank_add[b*AMW +: AMW]), 64'(ctx_add));
        chk("bank_wen_ctx", 64'(bank_wen[b]), 64'd1);
        chk("bank_be_ctx", 64'(bank_be[b*4 +: 4]), 64'hF);
      end else if (win[b] >= 0) begin
        p = win[b];
        chk("bank_add_dma", 64'(bank_add[b*AMW +: AMW]), 64'(p_addr[p][AMW+2:3]));
        chk("bank_wen_dma", 64'(bank_wen[b]), 64'(p_wen[p]));
        chk("bank_be_dma", 64'(bank_be[b*4 +: 4]), 64'(p_be[p]));
        if (!p_wen[p]) chk("bank_wdata", 64'(bank_wdata[b*DW +: DW]), 64'(p_wdata[p]));
      end
    end
    pv_dma = '0;
    pv_ctx = 1'b0;
    if (cw) begin
      ca     = int'(ctx_add);
      pv_ctx = 1'b1;
      pd_ctx = {ref_mem[ca*2], ref_mem[ca*2+1]};
    end
    for (int b = 0; b < 2; b++) if (win[b] >= 0) begin
      p = win[b];
      ri = int'(p_addr[p][7:2]);
      pv_dma[p] = 1'b1;
      if (p_wen[p]) pd_dma[p] = ref_mem[ri];
      else begin
        pd_dma[p] = '0;
        for (int k = 0; k < 4; k++) if (p_be[p][k]) ref_mem[ri][8*k +: 8] = p_wdata[p][8*k +: 8];
      end
      m_ptr[b] = (p + 1) % N;
    end
    if (rst) begin
      m_ptr[0] = 0; m_ptr[1] = 0; m_cnt = 0; m_yield = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i % 2, i / 2);
    end else if (cw) begin
      if (anyd) begin
        m_cnt++;
        if (m_cnt == MAXB) begin m_yield = 1; m_cnt = 0; end
      end else m_cnt = 0;
    end else begin
      m_cnt = 0; m_yield = 0;
    end
    m_gnt     = eg;
    m_ctx_gnt = cw;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    step(); adv();
  endtask

  task automatic idle_all();
    p_req = '0; ctx_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_all(); rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  logic [19:0] seq;

  initial begin
    rst = 1'b1; ctx_req = 1'b0; ctx_add = '0;
    for (int p = 0; p < N; p++) set_port(p, 0, 0, 1, 0, 4'hF);
    pv_dma = '0; pv_ctx = 0; m_gnt = '0; m_ctx_gnt = 0;
    adv();
    do_reset();

    // Reset state
    step();
    chk("rst_r_valid", 64'(dma_r_valid), 64'd0);
    chk("rst_ctx_r_valid", 64'(ctx_r_valid), 64'd0);
    chk("rst_ctx_rdata", ctx_r_rdata, 64'd0);
    chk("rst_bank_req", 64'(bank_req), 64'd0);
    adv();

    // Port0 reads 0x0 then port1 reads 0x4
    set_port(0, 1, 32'h0, 1, 0, 4'hF);
    step(); chk("t1_gnt0", 64'(dma_gnt), 64'b0001); chk("t1_bank0", 64'(bank_req), 64'b01); adv();
    p_req[0] = 0; set_port(1, 1, 32'h4, 1, 0, 4'hF);
    step(); chk("t1_gnt1", 64'(dma_gnt), 64'b0010); chk("t1_rv0", 64'(dma_r_valid), 64'b0001);
    chk("t1_rd0", 64'(dma_r_rdata[0 +: DW]), 64'h1000_0000); adv();
    p_req[1] = 0;
    step(); chk("t1_rv1", 64'(dma_r_valid), 64'b0010);
    chk("t1_rd1", 64'(dma_r_rdata[DW +: DW]), 64'h2000_0000); adv();

    // All ports read bank0 continuously: rotation 0,1,2,3,0
    do_reset();
    for (int p = 0; p < N; p++) set_port(p, 1, 32'(p * 8), 1, 0, 4'hF);
    for (int c = 0; c < 5; c++) begin
      step(); chk($sformatf("t2_rot%0d", c), 64'(dma_gnt), 64'(1 << (c % 4))); adv();
    end
    idle_all(); tick();

    // Two writes to bank0, one to bank1, readback, then ctx read of word 0x10
    do_reset();
    set_port(2, 1, 32'h84, 0, 32'h1234_5678, 4'hF);
    tick(); p_req[2] = 0;
    set_port(0, 1, 32'h80, 0, 32'hAAAA_5555, 4'hF);
    set_port(1, 1, 32'h88, 0, 32'hCAFE_F00D, 4'hF);
    step(); chk("t3_w0", 64'(dma_gnt), 64'b0001); adv(); p_req[0] = 0;
    step(); chk("t3_w1", 64'(dma_gnt), 64'b0010); adv(); p_req[1] = 0;
    set_port(0, 1, 32'h80, 1, 0, 4'hF);
    tick(); p_req[0] = 0;
    set_port(1, 1, 32'h88, 1, 0, 4'hF);
    step(); chk("t3_rb0", 64'(dma_r_rdata[0 +: DW]), 64'hAAAA_5555); adv(); p_req[1] = 0;
    ctx_req = 1'b1; ctx_add = 12'h010;
    step(); chk("t3_rb1", 64'(dma_r_rdata[DW +: DW]), 64'hCAFE_F00D); adv(); ctx_req = 1'b0;
    step(); chk("t5_ctx_rv", 64'(ctx_r_valid), 64'd1);
    chk("t5_ctx_rd", ctx_r_rdata, 64'hAAAA5555_12345678); adv();

    // ctx held 20 cycles against port2: 8 ctx, 1 DMA, 8 ctx, 1 DMA, 2 ctx
    do_reset();
    ctx_req = 1'b1; ctx_add = 12'h003;
    set_port(2, 1, 32'h10, 1, 0, 4'hF);
    for (int c = 0; c < 20; c++) begin
      step(); seq[c] = ctx_gnt; adv();
    end
    chk("t4_ctx_pattern", 64'(seq), 64'hDFEFF);
    idle_all(); tick();

    // Reset while a read is being granted, and while its response is in flight
    set_port(0, 1, 32'h0, 1, 0, 4'hF); rst = 1'b1;
    step(); chk("t6_gnt_in_rst", 64'(dma_gnt), 64'd0); adv();
    rst = 1'b0; p_req[0] = 0;
    step(); chk("t6_rv_after", 64'(dma_r_valid), 64'd0); adv();
    set_port(1, 1, 32'h8, 1, 0, 4'hF);
    step(); chk("t6_pre_gnt", 64'(dma_gnt), 64'b0010); adv();
    p_req[1] = 0; rst = 1'b1;
    tick(); rst = 1'b0;
    set_port(0, 1, 32'h0, 1, 0, 4'hF); set_port(2, 1, 32'h10, 1, 0, 4'hF);
    step(); chk("t6_rv_dropped", 64'(dma_r_valid), 64'd0);
    chk("t6_ptr_reset", 64'(dma_gnt), 64'b0001); adv();
    idle_all(); tick(); tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (p_req[p] && m_gnt[p]) p_req[p] = 0;
        if (!p_req[p] && $urandom_range(0, 99) < 40)
          set_port(p, 1, 32'($urandom_range(0, 63)) << 2, $urandom_range(0, 2) != 0,
                   $urandom, 4'($urandom_range(1, 15)));
      end
      if (ctx_req && m_ctx_gnt) ctx_req = 1'b0;
      if (!ctx_req && $urandom_range(0, 99) < (((c / 500) % 2 == 0) ? 90 : 30)) begin
        ctx_req = 1'b1;
        ctx_add = AMW'($urandom_range(0, 31));
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
